// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: load-use stall (LOAD_LAT bubbles), EX forwarding selects, redirect flush.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              mem_redirect,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic [ADDR_W-1:0] ex_rs1, ex_rs2;
  logic              hazard;
  logic              stall;

  assign hazard = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // cnt holds the bubbles still owed while in STALL, including the current one;
  // the detecting RUN cycle is itself the first bubble.
  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    stall        = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (enable) begin
      pc_en    = 1'b1;
      if_id_en = 1'b1;
      if (mem_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        next_state   = RUN;
        next_cnt     = '0;
      end else if (state == STALL) begin
        stall = 1'b1;
        if (cnt <= 4'd1) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end else if (hazard) begin
        stall = 1'b1;
        if (LOAD_LAT > 1) begin
          next_state = STALL;
          next_cnt   = 4'(LOAD_LAT - 1);
        end
      end
      if (stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= RUN;
      cnt    <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else if (enable) begin
      state  <= next_state;
      cnt    <= next_cnt;
      ex_rs1 <= id_ex_flush ? '0 : id_rs1;
      ex_rs2 <= id_ex_flush ? '0 : id_rs2;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
      return 2'b01;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1);
  assign fwd_b = fwd_sel(ex_rs2);

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (enable && mem_redirect && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1 and 3) checked every cycle against
// a bubble-counting reference model, plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int     AW = 5;
  localparam int     LAT [2]  = '{1, 3};
  localparam longint MAXC [2] = '{7, 64'd4294967295};

  logic          clk = 1'b0;
  logic          arst_n, enable, ex_memread, mem_regwrite, wb_regwrite, mem_redirect;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;

  logic [1:0] pc_en_v, if_id_en_v, if_id_flush_v, id_ex_flush_v, ex_mem_flush_v;
  logic [1:0] fwd_a_v [2];
  logic [1:0] fwd_b_v [2];
`ifdef HAZARD_STATS_EN
  logic [2:0]  sc0, fc0;
  logic [31:0] sc1, fc1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.ADDR_W(AW), .LOAD_LAT(1), .CNT_W(3)) dut0 (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_redirect(mem_redirect),
    .pc_en(pc_en_v[0]), .if_id_en(if_id_en_v[0]), .if_id_flush(if_id_flush_v[0]),
    .id_ex_flush(id_ex_flush_v[0]), .ex_mem_flush(ex_mem_flush_v[0]),
    .fwd_a(fwd_a_v[0]), .fwd_b(fwd_b_v[0])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc0), .flush_count(fc0)
`endif
  );

  pipeline_hazard_ctrl #(.ADDR_W(AW), .LOAD_LAT(3), .CNT_W(32)) dut1 (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_redirect(mem_redirect),
    .pc_en(pc_en_v[1]), .if_id_en(if_id_en_v[1]), .if_id_flush(if_id_flush_v[1]),
    .id_ex_flush(id_ex_flush_v[1]), .ex_mem_flush(ex_mem_flush_v[1]),
    .fwd_a(fwd_a_v[1]), .fwd_b(fwd_b_v[1])
`ifdef HAZARD_STATS_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d expected=%0d at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference model: bubbles still owed after the current cycle, and the operands sitting in EX.
  int            m_left [2];
  logic [AW-1:0] m_rs1  [2];
  logic [AW-1:0] m_rs2  [2];
  longint        m_sc   [2];
  longint        m_fc   [2];

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs)    return 2'b10;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic hz, stl, e_pc, e_ifid, e_f1, e_f2, e_f3;
      if (!arst_n) begin
        m_left[d] = 0; m_rs1[d] = '0; m_rs2[d] = '0; m_sc[d] = 0; m_fc[d] = 0;
      end
      hz  = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
      stl = 1'b0;
      {e_pc, e_ifid, e_f1, e_f2, e_f3} = 5'b0;
      if (enable) begin
        if (mem_redirect) {e_pc, e_ifid, e_f1, e_f2, e_f3} = 5'b11111;
        else if (m_left[d] > 0 || hz) begin stl = 1'b1; e_f2 = 1'b1; end
        else {e_pc, e_ifid} = 2'b11;
      end
      chk("pc_en", d, pc_en_v[d], e_pc);
      chk("if_id_en", d, if_id_en_v[d], e_ifid);
      chk("if_id_flush", d, if_id_flush_v[d], e_f1);
      chk("id_ex_flush", d, id_ex_flush_v[d], e_f2);
      chk("ex_mem_flush", d, ex_mem_flush_v[d], e_f3);
      chk("fwd_a", d, fwd_a_v[d], model_fwd(m_rs1[d]));
      chk("fwd_b", d, fwd_b_v[d], model_fwd(m_rs2[d]));
`ifdef HAZARD_STATS_EN
      chk("stall_count", d, (d == 0) ? 64'(sc0) : 64'(sc1), m_sc[d]);
      chk("flush_count", d, (d == 0) ? 64'(fc0) : 64'(fc1), m_fc[d]);
`endif
      if (arst_n && enable) begin
        if (mem_redirect) begin
          m_left[d] = 0; m_rs1[d] = '0; m_rs2[d] = '0;
          if (m_fc[d] < MAXC[d]) m_fc[d]++;
        end else if (stl) begin
          m_left[d] = (m_left[d] > 0) ? m_left[d] - 1 : LAT[d] - 1;
          m_rs1[d] = '0; m_rs2[d] = '0;
          if (m_sc[d] < MAXC[d]) m_sc[d]++;
        end else begin
          m_rs1[d] = id_rs1; m_rs2[d] = id_rs2;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    enable = 1'b1; ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    mem_redirect = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); quiet(); end
  endtask

  task automatic load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd1;
  endtask

  initial begin
`ifdef HAZARD_STATS_EN
    logic [31:0] base;
`endif
    arst_n = 1'b0;
    quiet();
    #1;
    chk("reset_fwd_a", 1, fwd_a_v[1], 2'b00);
    chk("reset_flush", 1, {if_id_flush_v[1], id_ex_flush_v[1], ex_mem_flush_v[1]}, 3'b000);
    @(posedge clk); @(posedge clk); #2 arst_n = 1'b1;
    idle(3);

    // load-use, LOAD_LAT 1 vs 3
    step(); load_use();
    @(negedge clk);
    chk("lu_pc_en_c1", 0, pc_en_v[0], 1'b0);
    chk("lu_bubble_c1", 0, id_ex_flush_v[0], 1'b1);
    chk("lu_pc_en_c1", 1, pc_en_v[1], 1'b0);
    step(); ex_memread = 1'b0;
    @(negedge clk);
    chk("lu_pc_en_c2", 0, pc_en_v[0], 1'b1);
    chk("lu_pc_en_c2", 1, pc_en_v[1], 1'b0);
    step(); @(negedge clk);
    chk("lu_pc_en_c3", 1, pc_en_v[1], 1'b0);
    step(); @(negedge clk);
    chk("lu_pc_en_c4", 1, pc_en_v[1], 1'b1);

    // forwarding priority
    idle(2);
    step(); quiet(); id_rs1 = 5'd7;
    step(); id_rs1 = '0; mem_rd = 5'd7; wb_rd = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    @(negedge clk);
    chk("fwd_mem_prio", 0, fwd_a_v[0], 2'b01);
    mem_regwrite = 1'b0; #1;
    chk("fwd_wb", 0, fwd_a_v[0], 2'b10);

    // x0 never stalls nor forwards
    idle(2);
    step(); ex_memread = 1'b1; ex_rd = '0; id_rs1 = '0; mem_rd = '0; mem_regwrite = 1'b1;
    @(negedge clk);
    chk("x0_no_stall", 0, pc_en_v[0], 1'b1);
    chk("x0_no_stall", 1, pc_en_v[1], 1'b1);
    step(); @(negedge clk);
    chk("x0_no_fwd", 0, fwd_a_v[0], 2'b00);

    // redirect in second stall cycle
    idle(3);
    step(); load_use();
    @(negedge clk);
    chk("rd_stall", 1, pc_en_v[1], 1'b0);
    step(); ex_memread = 1'b0; mem_redirect = 1'b1;
    @(negedge clk);
    chk("rd_flushes", 1, {if_id_flush_v[1], id_ex_flush_v[1], ex_mem_flush_v[1]}, 3'b111);
    chk("rd_pc_en", 1, pc_en_v[1], 1'b1);
    step(); mem_redirect = 1'b0;
    @(negedge clk);
    chk("rd_run_pc_en", 1, pc_en_v[1], 1'b1);
    chk("rd_run_bubble", 1, id_ex_flush_v[1], 1'b0);

    // enable low during a stall freezes the bubble count
    idle(3);
`ifdef HAZARD_STATS_EN
    base = sc1;
`endif
    step(); load_use();
    @(negedge clk);
    chk("en_stall1", 1, pc_en_v[1], 1'b0);
    step(); ex_memread = 1'b0; enable = 1'b0;
    @(negedge clk);
    chk("en_off_pc", 1, pc_en_v[1], 1'b0);
    chk("en_off_flush", 1, id_ex_flush_v[1], 1'b0);
    step();
    step(); enable = 1'b1;
    @(negedge clk);
    chk("en_stall2", 1, id_ex_flush_v[1], 1'b1);
    step(); @(negedge clk);
    chk("en_stall3", 1, id_ex_flush_v[1], 1'b1);
    step(); @(negedge clk);
    chk("en_resume", 1, pc_en_v[1], 1'b1);
`ifdef HAZARD_STATS_EN
    chk("en_stall_count", 1, 64'(sc1 - base), 64'd3);
`endif

    // async reset mid-stall releases the stall at once
    idle(3);
    step(); load_use();
    step(); ex_memread = 1'b0;
    #2 arst_n = 1'b0;
    @(negedge clk);
    chk("arst_release", 1, pc_en_v[1], 1'b1);
    @(posedge clk); #2 arst_n = 1'b1;
    @(negedge clk);
    chk("arst_run", 1, pc_en_v[1], 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      enable       = ($urandom_range(0, 9) != 0);
      mem_redirect = ($urandom_range(0, 11) == 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      mem_regwrite = $urandom_range(0, 1) != 0;
      wb_regwrite  = $urandom_range(0, 1) != 0;
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      ex_rd  = 5'($urandom_range(0, 7));
      mem_rd = 5'($urandom_range(0, 7));
      wb_rd  = 5'($urandom_range(0, 7));
      if (i == 1500) begin
        #2 arst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #2 arst_n = 1'b1;
      end
    end
    idle(2);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
